uc_stack: RTL and testbench

Parametrised sequential control unit for the 6-bit-opcode datapath. Decodes each instruction into datapath controls, drives one-hot enables for `NPORTS` output ports, and holds a hardware return-address stack of `STACK_DEPTH` entries for nested subroutines. It also stalls the PC on audio playback until the audio block reports completion. It sits between program ROM and datapath, replacing the single-entry backup register scheme.

---
 rtl/uc_stack.sv | 173 +++++++++++++++++
 tb/tb_uc_stack.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_stack.sv
// Sequential control unit: instruction decode, one-hot port enables, return-address stack, audio stall.
// Optional trap on stack overflow/underflow is enabled by defining UC_STACK_GUARD_EN.
module uc_stack #(
    parameter int NPORTS      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int PC_W        = 10,
    localparam int PW         = $clog2(NPORTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              z,
    input  logic [5:0]        opcode,
    input  logic [PW-1:0]     port_a,
    input  logic [PW-1:0]     port_b,
    input  logic [PC_W-1:0]   pc_plus1,
    input  logic              audio_done,
    output logic [2:0]        op,
    output logic              we3,
    output logic              s_inc,
    output logic              s_inm,
    output logic              sel_in,
    output logic              sel_out,
    output logic              s_rel,
    output logic              s_ret,
    output logic [NPORTS-1:0] port_en,
    output logic              audio_load,
    output logic              audio_start,
    output logic [PC_W-1:0]   ret_addr,
    output logic              fault
);

    localparam int AW = $clog2(STACK_DEPTH);
`ifdef UC_STACK_GUARD_EN
    // One extra bit so a full stack (sp == STACK_DEPTH) is distinguishable from empty.
    localparam int SP_W = AW + 1;
`else
    localparam int SP_W = AW;
`endif

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);
    localparam logic [NPORTS-1:0] PORT_ONE = NPORTS'(1);

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_dec;
    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic            push;
    logic            pop;
    logic            stack_full;
    logic            stack_empty;

    function automatic logic [NPORTS-1:0] port_onehot(input logic [PW-1:0] idx);
        return PORT_ONE << idx;
    endfunction

    assign sp_dec = sp - SP_ONE;

`ifdef UC_STACK_GUARD_EN
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
`else
    // Without the guard the pointer simply wraps, so neither condition traps.
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b0;
`endif

    assign op = opcode[2:0];

    always_comb begin
        we3         = 1'b0;
        s_inc       = 1'b1;
        s_inm       = 1'b0;
        sel_in      = 1'b0;
        sel_out     = 1'b0;
        s_rel       = 1'b0;
        s_ret       = 1'b0;
        port_en     = '0;
        audio_load  = 1'b0;
        audio_start = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        state_next  = state;

        if (reset) begin
            state_next = S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    // Patterns are disjoint, so listing order matches first-match priority.
                    casez (opcode)
                        6'b??0???: we3 = 1'b1;
                        6'b??1000: begin
                            we3   = 1'b1;
                            s_inm = 1'b1;
                        end
                        6'b001001: s_inc = 1'b0;
                        6'b001010: s_inc = !z;
                        6'b001011: s_inc = z;
                        6'b001100: begin
                            we3    = 1'b1;
                            sel_in = 1'b1;
                        end
                        6'b001101: begin
                            sel_out = 1'b1;
                            port_en = port_onehot(port_a);
                        end
                        6'b001110: port_en = port_onehot(port_a);
                        6'b??1111: begin
                            sel_out = 1'b1;
                            port_en = port_onehot(port_b);
                        end
                        6'b011001: s_rel = 1'b1;
                        6'b011010: begin
                            s_inc = 1'b0;
                            if (stack_full) state_next = S_FAULT;
                            else            push       = 1'b1;
                        end
                        6'b011011: begin
                            s_inc = 1'b0;
                            s_ret = 1'b1;
                            if (stack_empty) state_next = S_FAULT;
                            else             pop        = 1'b1;
                        end
                        6'b011100: audio_load = 1'b1;
                        6'b011101: begin
                            audio_start = 1'b1;
                            s_inc       = 1'b0;
                            state_next  = S_WAIT;
                        end
                        default: ;
                    endcase
                end
                S_WAIT: begin
                    // PC released in the same cycle the audio block reports completion.
                    s_inc = audio_done;
                    if (audio_done) state_next = S_RUN;
                end
                S_FAULT: s_inc = 1'b0;
                default: state_next = S_RUN;
            endcase
        end
    end

`ifdef UC_STACK_GUARD_EN
    assign fault = !reset && (state == S_FAULT);
`else
    assign fault = 1'b0;
`endif

    assign ret_addr = reset ? '0 : mem[sp_dec[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
            sp    <= '0;
        end else begin
            state <= state_next;
            if (push)     sp <= sp + SP_ONE;
            else if (pop) sp <= sp_dec;
        end
    end

    // Stack contents are data: never reset, written only on a push.
    always_ff @(posedge clk) begin
        if (push) mem[sp[AW-1:0]] <= pc_plus1;
    end

endmodule

// File: tb/tb_uc_stack.sv
// Directed self-checking bench for uc_stack (NPORTS=8, STACK_DEPTH=4); follows UC_STACK_GUARD_EN if defined.
module tb_uc_stack;

    localparam int NPORTS      = 8;
    localparam int STACK_DEPTH = 4;
    localparam int PC_W        = 10;
    localparam int PW          = 3;

    localparam logic [5:0] OP_ALU  = 6'b010000;
    localparam logic [5:0] OP_NOP  = 6'b111001;
    localparam logic [5:0] OP_CALL = 6'b011010;
    localparam logic [5:0] OP_RET  = 6'b011011;
    localparam logic [5:0] OP_PLAY = 6'b011101;

    logic              clk = 1'b0;
    logic              reset;
    logic              z;
    logic [5:0]        opcode;
    logic [PW-1:0]     port_a;
    logic [PW-1:0]     port_b;
    logic [PC_W-1:0]   pc_plus1;
    logic              audio_done;
    logic [2:0]        op;
    logic              we3, s_inc, s_inm, sel_in, sel_out, s_rel, s_ret;
    logic [NPORTS-1:0] port_en;
    logic              audio_load, audio_start;
    logic [PC_W-1:0]   ret_addr;
    logic              fault;
    logic [8:0]        ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    // {we3, s_inc, s_inm, sel_in, sel_out, s_rel, s_ret, audio_load, audio_start}
    assign ctrl = {we3, s_inc, s_inm, sel_in, sel_out, s_rel, s_ret, audio_load, audio_start};

    uc_stack #(.NPORTS(NPORTS), .STACK_DEPTH(STACK_DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .z(z), .opcode(opcode), .port_a(port_a), .port_b(port_b),
        .pc_plus1(pc_plus1), .audio_done(audio_done), .op(op), .we3(we3), .s_inc(s_inc),
        .s_inm(s_inm), .sel_in(sel_in), .sel_out(sel_out), .s_rel(s_rel), .s_ret(s_ret),
        .port_en(port_en), .audio_load(audio_load), .audio_start(audio_start),
        .ret_addr(ret_addr), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic apply_reset;
        reset  = 1'b1;
        opcode = OP_NOP;
        tick();
        reset  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; opcode = OP_PLAY; audio_done = 1'b0; z = 1'b0;
        port_a = '0; port_b = '0; pc_plus1 = '0;
        for (int i = 0; i < 2; i++) begin
            settle();
            if ({ctrl, port_en, fault} !== {9'b010000000, 8'h00, 1'b0}) begin
                $display("FAIL reset_defaults cycle %0d actual=%b/%h/%b required=010000000/00/0", i, ctrl, port_en, fault);
                n_fail++;
            end
            n_checks++;
            tick();
        end
        reset = 1'b0;
        settle();
        if (ctrl !== 9'b000000001) begin
            $display("FAIL reset_release_play actual=%b required=000000001", ctrl); n_fail++;
        end
        n_checks++;
        tick();
        settle();
        if (ctrl !== 9'b000000000) begin
            $display("FAIL reset_wait1 actual=%b required=000000000", ctrl); n_fail++;
        end
        n_checks++;
        opcode = OP_NOP;
        tick();
        settle();
        if (ctrl !== 9'b000000000) begin
            $display("FAIL reset_wait2 actual=%b required=000000000", ctrl); n_fail++;
        end
        n_checks++;
        audio_done = 1'b1;
        settle();
        if (ctrl !== 9'b010000000) begin
            $display("FAIL reset_wait_done actual=%b required=010000000", ctrl); n_fail++;
        end
        n_checks++;
        tick();
        audio_done = 1'b0; opcode = OP_ALU;
        settle();
        if (ctrl !== 9'b110000000) begin
            $display("FAIL reset_back_to_run actual=%b required=110000000", ctrl); n_fail++;
        end
        n_checks++;
    endtask

    typedef struct packed {
        logic [5:0] opc;
        logic       zz;
        logic [2:0] pa;
        logic [2:0] pb;
        logic [8:0] ctl;
        logic [7:0] pe;
    } row_t;

    task automatic test_decode;
        row_t rows[15];
        rows[0]  = '{6'b010000, 1'b0, 3'd0, 3'd0, 9'b110000000, 8'h00};
        rows[1]  = '{6'b001101, 1'b0, 3'd5, 3'd0, 9'b010010000, 8'h20};
        rows[2]  = '{6'b111111, 1'b0, 3'd0, 3'd2, 9'b010010000, 8'h04};
        rows[3]  = '{6'b001010, 1'b1, 3'd0, 3'd0, 9'b000000000, 8'h00};
        rows[4]  = '{6'b001010, 1'b0, 3'd0, 3'd0, 9'b010000000, 8'h00};
        rows[5]  = '{6'b001011, 1'b1, 3'd0, 3'd0, 9'b010000000, 8'h00};
        rows[6]  = '{6'b001011, 1'b0, 3'd0, 3'd0, 9'b000000000, 8'h00};
        rows[7]  = '{6'b101000, 1'b0, 3'd0, 3'd0, 9'b111000000, 8'h00};
        rows[8]  = '{6'b001100, 1'b0, 3'd0, 3'd0, 9'b110100000, 8'h00};
        rows[9]  = '{6'b001110, 1'b0, 3'd3, 3'd6, 9'b010000000, 8'h08};
        rows[10] = '{6'b011001, 1'b0, 3'd0, 3'd0, 9'b010001000, 8'h00};
        rows[11] = '{6'b011100, 1'b0, 3'd0, 3'd0, 9'b010000010, 8'h00};
        rows[12] = '{6'b111001, 1'b0, 3'd0, 3'd0, 9'b010000000, 8'h00};
        rows[13] = '{6'b001001, 1'b0, 3'd0, 3'd0, 9'b000000000, 8'h00};
        rows[14] = '{6'b000111, 1'b1, 3'd7, 3'd1, 9'b110000000, 8'h00};
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            opcode = rows[i].opc; z = rows[i].zz; port_a = rows[i].pa; port_b = rows[i].pb;
            settle();
            if ({ctrl, port_en} !== {rows[i].ctl, rows[i].pe}) begin
                $display("FAIL decode row %0d opcode %b actual=%b/%h required=%b/%h",
                         i, rows[i].opc, ctrl, port_en, rows[i].ctl, rows[i].pe);
                n_fail++;
            end
            n_checks++;
            tick();
        end
        opcode = 6'b000111;
        settle();
        if (op !== 3'b111) begin
            $display("FAIL decode_op_111 actual=%b required=111", op); n_fail++;
        end
        n_checks++;
        opcode = OP_ALU;
        settle();
        if (op !== 3'b000) begin
            $display("FAIL decode_op_000 actual=%b required=000", op); n_fail++;
        end
        n_checks++;
        z = 1'b0; port_a = '0; port_b = '0;
    endtask

    task automatic test_stack;
        logic [PC_W-1:0] full_vals[4];
        logic [PC_W-1:0] part_vals[3];
        full_vals = '{10'h101, 10'h102, 10'h103, 10'h104};
        part_vals = '{10'h010, 10'h020, 10'h030};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            opcode = OP_CALL; pc_plus1 = full_vals[i];
            settle();
            if (ctrl !== 9'b000000000) begin
                $display("FAIL stack_call_full %0d actual=%b required=000000000", i, ctrl); n_fail++;
            end
            n_checks++;
            tick();
        end
        for (int i = 3; i >= 0; i--) begin
            opcode = OP_RET;
            settle();
            if ({ctrl, ret_addr} !== {9'b000000100, full_vals[i]}) begin
                $display("FAIL stack_ret_full %0d actual=%b/%h required=000000100/%h", i, ctrl, ret_addr, full_vals[i]);
                n_fail++;
            end
            n_checks++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            opcode = OP_CALL; pc_plus1 = part_vals[i];
            tick();
        end
        for (int i = 2; i >= 0; i--) begin
            opcode = OP_RET;
            settle();
            if (ret_addr !== part_vals[i]) begin
                $display("FAIL stack_ret_order %0d actual=%h required=%h", i, ret_addr, part_vals[i]); n_fail++;
            end
            n_checks++;
            tick();
        end
        // With sp back at 0, the top-of-stack view points at entry STACK_DEPTH-1.
        opcode = OP_NOP;
        settle();
        if (ret_addr !== 10'h104) begin
            $display("FAIL stack_final_sp_zero actual=%h required=104", ret_addr); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_overflow;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            opcode = OP_CALL; pc_plus1 = PC_W'(10'h201 + i);
            settle();
            if (ctrl !== 9'b000000000) begin
                $display("FAIL overflow_call %0d actual=%b required=000000000", i, ctrl); n_fail++;
            end
            n_checks++;
            tick();
        end
        opcode = OP_ALU;
        settle();
`ifdef UC_STACK_GUARD_EN
        if ({fault, ctrl} !== {1'b1, 9'b000000000}) begin
            $display("FAIL overflow_fault actual=%b/%b required=1/000000000", fault, ctrl); n_fail++;
        end
        n_checks++;
        opcode = 6'b001101; port_a = 3'd5;
        settle();
        if (port_en !== 8'h00) begin
            $display("FAIL overflow_port_en actual=%h required=00", port_en); n_fail++;
        end
        n_checks++;
        tick();
        opcode = OP_ALU;
        settle();
        if (fault !== 1'b1) begin
            $display("FAIL overflow_fault_held actual=%b required=1", fault); n_fail++;
        end
        n_checks++;
        reset = 1'b1;
        settle();
        if ({fault, ctrl} !== {1'b0, 9'b010000000}) begin
            $display("FAIL overflow_in_reset actual=%b/%b required=0/010000000", fault, ctrl); n_fail++;
        end
        n_checks++;
        tick();
        reset = 1'b0;
        settle();
        if ({fault, ctrl} !== {1'b0, 9'b110000000}) begin
            $display("FAIL overflow_cleared actual=%b/%b required=0/110000000", fault, ctrl); n_fail++;
        end
        n_checks++;
`else
        if ({fault, ctrl} !== {1'b0, 9'b110000000}) begin
            $display("FAIL overflow_wrap_nofault actual=%b/%b required=0/110000000", fault, ctrl); n_fail++;
        end
        n_checks++;
        opcode = OP_RET;
        settle();
        if (ret_addr !== 10'h205) begin
            $display("FAIL overflow_wrap_top actual=%h required=205", ret_addr); n_fail++;
        end
        n_checks++;
        tick();
        settle();
        if (ret_addr !== 10'h204) begin
            $display("FAIL overflow_wrap_under actual=%h required=204", ret_addr); n_fail++;
        end
        n_checks++;
        tick();
`endif
        port_a = '0;
        apply_reset();
    endtask

    task automatic test_underflow;
        apply_reset();
        opcode = OP_RET;
        settle();
        if (ctrl !== 9'b000000100) begin
            $display("FAIL underflow_ret actual=%b required=000000100", ctrl); n_fail++;
        end
        n_checks++;
        tick();
        opcode = OP_ALU;
        settle();
`ifdef UC_STACK_GUARD_EN
        if ({fault, ctrl} !== {1'b1, 9'b000000000}) begin
            $display("FAIL underflow_fault actual=%b/%b required=1/000000000", fault, ctrl); n_fail++;
        end
        n_checks++;
`else
        if ({fault, ctrl, ret_addr} !== {1'b0, 9'b110000000, 10'h203}) begin
            $display("FAIL underflow_wrap actual=%b/%b/%h required=0/110000000/203", fault, ctrl, ret_addr); n_fail++;
        end
        n_checks++;
`endif
        apply_reset();
    endtask

    task automatic test_play_wait;
        apply_reset();
        opcode = OP_PLAY; audio_done = 1'b0;
        settle();
        if (ctrl !== 9'b000000001) begin
            $display("FAIL play_start actual=%b required=000000001", ctrl); n_fail++;
        end
        n_checks++;
        tick();
        opcode = OP_NOP;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (ctrl !== 9'b000000000) begin
                $display("FAIL play_hold cycle %0d actual=%b required=000000000", i, ctrl); n_fail++;
            end
            n_checks++;
            tick();
        end
        audio_done = 1'b1;
        settle();
        if (ctrl !== 9'b010000000) begin
            $display("FAIL play_done actual=%b required=010000000", ctrl); n_fail++;
        end
        n_checks++;
        tick();
        audio_done = 1'b0; opcode = OP_ALU;
        settle();
        if (ctrl !== 9'b110000000) begin
            $display("FAIL play_resume actual=%b required=110000000", ctrl); n_fail++;
        end
        n_checks++;
        // Minimum two-cycle PLAY: done already high on the first wait cycle.
        opcode = OP_PLAY; audio_done = 1'b1;
        tick();
        opcode = OP_NOP;
        settle();
        if (ctrl !== 9'b010000000) begin
            $display("FAIL play_min_exit actual=%b required=010000000", ctrl); n_fail++;
        end
        n_checks++;
        tick();
        audio_done = 1'b0; opcode = OP_ALU;
        settle();
        if (ctrl !== 9'b110000000) begin
            $display("FAIL play_min_resume actual=%b required=110000000", ctrl); n_fail++;
        end
        n_checks++;
        // Reset while waiting on audio.
        opcode = OP_PLAY;
        tick();
        opcode = OP_ALU;
        settle();
        if (ctrl !== 9'b000000000) begin
            $display("FAIL play_wait_gates_alu actual=%b required=000000000", ctrl); n_fail++;
        end
        n_checks++;
        reset = 1'b1;
        settle();
        if (ctrl !== 9'b010000000) begin
            $display("FAIL play_reset_defaults actual=%b required=010000000", ctrl); n_fail++;
        end
        n_checks++;
        tick();
        reset = 1'b0;
        settle();
        if (ctrl !== 9'b110000000) begin
            $display("FAIL play_reset_to_run actual=%b required=110000000", ctrl); n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_stack();
        test_overflow();
        test_underflow();
        test_play_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
